// File: rtl/layer_seq_pkg.sv
// Shared types for the layer sequencer: FSM state encoding.
package layer_seq_pkg;

  localparam int unsigned StateWidth = 3;

  typedef enum logic [StateWidth-1:0] {
    StIdle    = 3'd0,
    StFwIssue = 3'd1,
    StFwWait  = 3'd2,
    StBwIssue = 3'd3,
    StBwWait  = 3'd4
  } state_e;

endpackage

// File: rtl/stall_watchdog.sv
// Saturating stall counter; expired_o is high while the count sits at all-ones.
module stall_watchdog #(
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clear_i,
  output logic expired_o
);

  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

  assign expired_o = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/layer_sequencer.sv
// Issues forward then backward layer tokens per training sample, with sample counting,
// stop handling and a stall watchdog.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int unsigned LAYER_ADDR_WIDTH = 2,
  parameter int unsigned LAYER_MAX        = 2,
  parameter int unsigned SAMPLE_WIDTH     = 10,
  parameter int unsigned TIMEOUT_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        stop_i,
  input  logic [SAMPLE_WIDTH-1:0]     num_samples_i,
  output logic [LAYER_ADDR_WIDTH-1:0] fw_layer_o,
  output logic                        fw_layer_valid_o,
  input  logic                        fw_layer_ready_i,
  output logic [LAYER_ADDR_WIDTH-1:0] bw_layer_o,
  output logic                        bw_layer_valid_o,
  input  logic                        bw_layer_ready_i,
  input  logic                        fw_done_i,
  input  logic                        bw_done_i,
  output logic                        busy_o,
  output logic [SAMPLE_WIDTH-1:0]     sample_idx_o,
  output logic                        run_done_o,
  output logic                        timeout_o
);

  localparam logic [LAYER_ADDR_WIDTH-1:0] LayerTop   = LAYER_ADDR_WIDTH'(LAYER_MAX);
  localparam logic [LAYER_ADDR_WIDTH-1:0] LayerTopM1 = LAYER_ADDR_WIDTH'(LAYER_MAX - 1);
  localparam logic                        BwLastInit = (LAYER_MAX == 1);

  state_e                      state_q, state_d;
  logic [LAYER_ADDR_WIDTH-1:0] fw_layer_q, fw_layer_d, bw_layer_q, bw_layer_d;
  logic                        fw_valid_q, fw_valid_d, bw_valid_q, bw_valid_d;
  logic                        bw_last_q, bw_last_d;
  logic                        fw_pend_q, fw_pend_d, bw_pend_q, bw_pend_d;
  logic [SAMPLE_WIDTH-1:0]     num_q, num_d, sample_idx_q, sample_idx_d;
  logic                        run_done_q, run_done_d, timeout_q, timeout_d;
  logic                        fw_hs, bw_hs, is_last, wd_clear, wd_expired;

  assign fw_hs   = fw_valid_q & fw_layer_ready_i;
  assign bw_hs   = bw_valid_q & bw_layer_ready_i;
  assign is_last = (sample_idx_q == num_q - SAMPLE_WIDTH'(1));

  always_comb begin
    state_d      = state_q;
    fw_layer_d   = fw_layer_q;
    fw_valid_d   = fw_valid_q;
    bw_layer_d   = bw_layer_q;
    bw_valid_d   = bw_valid_q;
    bw_last_d    = bw_last_q;
    fw_pend_d    = fw_pend_q;
    bw_pend_d    = bw_pend_q;
    num_d        = num_q;
    sample_idx_d = sample_idx_q;
    run_done_d   = 1'b0;
    timeout_d    = timeout_q;

    case (state_q)
      StIdle: begin
        if (start_i && !timeout_q) begin
          state_d      = StFwIssue;
          fw_layer_d   = '0;
          fw_valid_d   = 1'b1;
          fw_pend_d    = 1'b0;
          bw_pend_d    = 1'b0;
          sample_idx_d = '0;
          num_d        = (num_samples_i == '0) ? SAMPLE_WIDTH'(1) : num_samples_i;
        end
      end
      StFwIssue: begin
        if (fw_done_i) fw_pend_d = 1'b1;
        if (fw_hs) begin
          if (fw_layer_q == LayerTop) begin
            fw_valid_d = 1'b0;
            state_d    = StFwWait;
          end else begin
            fw_layer_d = fw_layer_q + LAYER_ADDR_WIDTH'(1);
          end
        end
      end
      StFwWait: begin
        if (fw_done_i || fw_pend_q) begin
          state_d    = StBwIssue;
          fw_pend_d  = 1'b0;
          bw_pend_d  = 1'b0;
          bw_layer_d = LayerTopM1;
          bw_last_d  = BwLastInit;
          bw_valid_d = 1'b1;
        end
      end
      StBwIssue: begin
        if (bw_done_i) bw_pend_d = 1'b1;
        if (bw_hs) begin
          // The last-token flag stops the count at 0 instead of relying on wraparound.
          if (bw_last_q) begin
            bw_valid_d = 1'b0;
            state_d    = StBwWait;
          end else begin
            bw_layer_d = bw_layer_q - LAYER_ADDR_WIDTH'(1);
            bw_last_d  = (bw_layer_q == LAYER_ADDR_WIDTH'(1));
          end
        end
      end
      StBwWait: begin
        if (bw_done_i || bw_pend_q) begin
          bw_pend_d = 1'b0;
          if (is_last || stop_i) begin
            run_done_d   = is_last;
            sample_idx_d = '0;
            state_d      = StIdle;
          end else begin
            sample_idx_d = sample_idx_q + SAMPLE_WIDTH'(1);
            fw_layer_d   = '0;
            fw_valid_d   = 1'b1;
            state_d      = StFwIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (wd_expired) begin
      state_d      = StIdle;
      timeout_d    = 1'b1;
      fw_valid_d   = 1'b0;
      bw_valid_d   = 1'b0;
      fw_pend_d    = 1'b0;
      bw_pend_d    = 1'b0;
      run_done_d   = 1'b0;
      sample_idx_d = '0;
    end
  end

  assign wd_clear = (state_d != state_q) || fw_hs || bw_hs;

  stall_watchdog #(
    .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .en_i     (busy_o),
    .clear_i  (wd_clear),
    .expired_o(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      fw_layer_q   <= '0;
      fw_valid_q   <= 1'b0;
      bw_layer_q   <= LayerTopM1;
      bw_valid_q   <= 1'b0;
      bw_last_q    <= BwLastInit;
      fw_pend_q    <= 1'b0;
      bw_pend_q    <= 1'b0;
      num_q        <= SAMPLE_WIDTH'(1);
      sample_idx_q <= '0;
      run_done_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fw_layer_q   <= fw_layer_d;
      fw_valid_q   <= fw_valid_d;
      bw_layer_q   <= bw_layer_d;
      bw_valid_q   <= bw_valid_d;
      bw_last_q    <= bw_last_d;
      fw_pend_q    <= fw_pend_d;
      bw_pend_q    <= bw_pend_d;
      num_q        <= num_d;
      sample_idx_q <= sample_idx_d;
      run_done_q   <= run_done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign fw_layer_o       = fw_layer_q;
  assign fw_layer_valid_o = fw_valid_q;
  assign bw_layer_o       = bw_layer_q;
  assign bw_layer_valid_o = bw_valid_q;
  assign busy_o           = (state_q != StIdle);
  assign sample_idx_o     = sample_idx_q;
  assign run_done_o       = run_done_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: token order/stability, sample counting, stop, watchdog.
module tb_layer_sequencer;

  localparam int unsigned LW = 2;
  localparam int unsigned LM = 2;
  localparam int unsigned SW = 10;
  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, stop = 1'b0;
  logic [SW-1:0] num_samples = '0;
  logic [LW-1:0] fw_layer, bw_layer;
  logic          fw_valid, bw_valid;
  logic          fw_ready = 1'b1, bw_ready = 1'b1;
  logic          fw_done = 1'b0, bw_done = 1'b0;
  logic          busy, run_done, timeout;
  logic [SW-1:0] sample_idx;

  always #5 clk = ~clk;

  layer_sequencer #(
    .LAYER_ADDR_WIDTH(LW),
    .LAYER_MAX       (LM),
    .SAMPLE_WIDTH    (SW),
    .TIMEOUT_WIDTH   (TW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start),
    .stop_i          (stop),
    .num_samples_i   (num_samples),
    .fw_layer_o      (fw_layer),
    .fw_layer_valid_o(fw_valid),
    .fw_layer_ready_i(fw_ready),
    .bw_layer_o      (bw_layer),
    .bw_layer_valid_o(bw_valid),
    .bw_layer_ready_i(bw_ready),
    .fw_done_i       (fw_done),
    .bw_done_i       (bw_done),
    .busy_o          (busy),
    .sample_idx_o    (sample_idx),
    .run_done_o      (run_done),
    .timeout_o       (timeout)
  );

  int checks = 0;
  int errors = 0;
  int exp_fw[$];
  int exp_bw[$];
  int exp_idx[$];
  int fw_hs_cnt = 0;
  int run_done_cnt = 0;
  bit bp_en = 1'b0;

  task automatic sb_push(input int n, input bit with_bw);
    for (int s = 0; s < n; s++) begin
      exp_idx.push_back(s);
      for (int k = 0; k <= int'(LM); k++) exp_fw.push_back(k);
      if (with_bw) for (int k = int'(LM) - 1; k >= 0; k--) exp_bw.push_back(k);
    end
  endtask

  task automatic monitor();
    bit            fw_stall = 1'b0, bw_stall = 1'b0, rd_prev = 1'b0;
    logic [LW-1:0] fw_hold = '0, bw_hold = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fw_stall = 1'b0; bw_stall = 1'b0; rd_prev = 1'b0;
        continue;
      end
      if (fw_stall) begin
        checks++;
        if (fw_valid !== 1'b1 || fw_layer !== fw_hold) begin
          errors++;
          $display("FAIL fw_stable: valid=%0b layer=%0d, required valid=1 layer=%0d",
                   fw_valid, fw_layer, fw_hold);
        end
      end
      if (bw_stall) begin
        checks++;
        if (bw_valid !== 1'b1 || bw_layer !== bw_hold) begin
          errors++;
          $display("FAIL bw_stable: valid=%0b layer=%0d, required valid=1 layer=%0d",
                   bw_valid, bw_layer, bw_hold);
        end
      end
      if (fw_valid && fw_ready) begin
        checks++;
        fw_hs_cnt++;
        if (exp_fw.size() == 0) begin
          errors++;
          $display("FAIL fw_token: got unexpected token %0d, required none", fw_layer);
        end else begin
          int e;
          e = exp_fw.pop_front();
          if (fw_layer !== LW'(e)) begin
            errors++;
            $display("FAIL fw_token: got %0d, required %0d", fw_layer, e);
          end
          if (e == 0 && exp_idx.size() != 0) begin
            int ei;
            ei = exp_idx.pop_front();
            checks++;
            if (sample_idx !== SW'(ei)) begin
              errors++;
              $display("FAIL sample_idx: got %0d, required %0d", sample_idx, ei);
            end
          end
        end
      end
      if (bw_valid && bw_ready) begin
        checks++;
        if (exp_bw.size() == 0) begin
          errors++;
          $display("FAIL bw_token: got unexpected token %0d, required none", bw_layer);
        end else begin
          int e;
          e = exp_bw.pop_front();
          if (bw_layer !== LW'(e)) begin
            errors++;
            $display("FAIL bw_token: got %0d, required %0d", bw_layer, e);
          end
        end
      end
      if (run_done) begin
        run_done_cnt++;
        checks++;
        if (rd_prev) begin
          errors++;
          $display("FAIL run_done_width: high 2 cycles, required 1-cycle pulse");
        end
      end
      fw_stall = fw_valid && !fw_ready;
      fw_hold  = fw_layer;
      bw_stall = bw_valid && !bw_ready;
      bw_hold  = bw_layer;
      rd_prev  = run_done;
    end
  endtask

  // Random backpressure, capped at 3 stalled cycles so the short watchdog never fires.
  task automatic ready_driver();
    int fs = 0, bs = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        fw_ready = (fs >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        bw_ready = (bs >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        fs = fw_ready ? 0 : fs + 1;
        bs = bw_ready ? 0 : bs + 1;
      end else begin
        fw_ready = 1'b1;
        bw_ready = 1'b1;
        fs = 0;
        bs = 0;
      end
    end
  endtask

  task automatic do_start(input int n);
    num_samples = SW'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_fw_last(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fw_valid && fw_ready && fw_layer == LW'(LM)) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL fw_last_wait: token %0d never transferred within 100 cycles", LM);
    end
  endtask

  task automatic wait_bw_last(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bw_valid && bw_ready && bw_layer == '0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL bw_last_wait: token 0 never transferred within 100 cycles");
    end
  endtask

  // Called at a negedge; delay 0 makes the pulse coincide with the pending transfer edge.
  task automatic pulse_fw(input int delay);
    if (delay > 0) begin
      repeat (delay) @(posedge clk);
      #1;
    end
    fw_done = 1'b1;
    @(posedge clk); #1;
    fw_done = 1'b0;
  endtask

  task automatic pulse_bw(input int delay);
    if (delay > 0) begin
      repeat (delay) @(posedge clk);
      #1;
    end
    bw_done = 1'b1;
    @(posedge clk); #1;
    bw_done = 1'b0;
  endtask

  task automatic sample_ctrl(input int fd, input int bd);
    bit ok;
    wait_fw_last(ok);
    if (ok) pulse_fw(fd);
    wait_bw_last(ok);
    if (ok) pulse_bw(bd);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_wait: busy still 1 after 100 cycles, required 0");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (exp_fw.size() != 0 || exp_bw.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_empty: fw left=%0d bw left=%0d, required 0 0",
               name, exp_fw.size(), exp_bw.size());
    end
    exp_fw.delete(); exp_bw.delete(); exp_idx.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (fw_valid !== 1'b0 || bw_valid !== 1'b0 || fw_layer !== '0 || bw_layer !== LW'(LM - 1) ||
        sample_idx !== '0 || busy !== 1'b0 || run_done !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset: fv=%0b bv=%0b fl=%0d bl=%0d idx=%0d busy=%0b rd=%0b to=%0b, required 0 0 0 %0d 0 0 0 0",
               fw_valid, bw_valid, fw_layer, bw_layer, sample_idx, busy, run_done, timeout, LM - 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int rd0 = run_done_cnt;
    sb_push(1, 1'b1);
    do_start(1);
    for (int k = 0; k <= int'(LM); k++) begin
      @(negedge clk);
      checks++;
      if (fw_valid !== 1'b1 || fw_layer !== LW'(k) || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_fw_seq: valid=%0b layer=%0d busy=%0b, required 1 %0d 1",
                 fw_valid, fw_layer, busy, k);
      end
    end
    @(negedge clk);
    checks++;
    if (fw_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_fw_drop: valid=%0b, required 0", fw_valid);
    end
    pulse_fw(2);
    for (int k = int'(LM) - 1; k >= 0; k--) begin
      @(negedge clk);
      checks++;
      if (bw_valid !== 1'b1 || bw_layer !== LW'(k)) begin
        errors++;
        $display("FAIL single_bw_seq: valid=%0b layer=%0d, required 1 %0d", bw_valid, bw_layer, k);
      end
    end
    @(negedge clk);
    pulse_bw(2);
    @(negedge clk);
    checks++;
    if (run_done !== 1'b1 || busy !== 1'b0 || sample_idx !== '0) begin
      errors++;
      $display("FAIL single_done: run_done=%0b busy=%0b idx=%0d, required 1 0 0",
               run_done, busy, sample_idx);
    end
    @(negedge clk);
    checks++;
    if (run_done !== 1'b0 || run_done_cnt != rd0 + 1) begin
      errors++;
      $display("FAIL single_pulse: run_done=%0b count=%0d, required 0 %0d",
               run_done, run_done_cnt - rd0, 1);
    end
    @(posedge clk); #1;
    check_sb_empty("single");
  endtask

  task automatic test_backpressure();
    int rd0 = run_done_cnt;
    bp_en = 1'b1;
    sb_push(3, 1'b1);
    do_start(3);
    for (int s = 0; s < 3; s++) sample_ctrl($urandom_range(0, 3), $urandom_range(0, 3));
    wait_idle();
    bp_en = 1'b0;
    checks++;
    if (run_done_cnt != rd0 + 1) begin
      errors++;
      $display("FAIL bp_run_done: count=%0d, required 1", run_done_cnt - rd0);
    end
    check_sb_empty("bp");
  endtask

  task automatic test_multi();
    int rd0 = run_done_cnt;
    sb_push(3, 1'b1);
    do_start(3);
    sample_ctrl(1, 1);
    sample_ctrl(2, 1);
    checks++;
    if (run_done_cnt != rd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL multi_mid: run_done count=%0d busy=%0b, required 0 1", run_done_cnt - rd0, busy);
    end
    sample_ctrl(1, 2);
    wait_idle();
    checks++;
    if (run_done_cnt != rd0 + 1 || sample_idx !== '0) begin
      errors++;
      $display("FAIL multi_end: run_done count=%0d idx=%0d, required 1 0",
               run_done_cnt - rd0, sample_idx);
    end
    check_sb_empty("multi");
  endtask

  task automatic test_early_fw_done();
    bit ok;
    sb_push(1, 1'b1);
    do_start(1);
    wait_fw_last(ok);
    pulse_fw(0);
    @(negedge clk);
    checks++;
    if (bw_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_fw_wait: bw_valid=%0b, required 0", bw_valid);
    end
    @(negedge clk);
    checks++;
    if (bw_valid !== 1'b1 || bw_layer !== LW'(LM - 1)) begin
      errors++;
      $display("FAIL early_fw_bw: bw_valid=%0b layer=%0d, required 1 %0d", bw_valid, bw_layer, LM - 1);
    end
    wait_bw_last(ok);
    if (ok) pulse_bw(1);
    wait_idle();
    check_sb_empty("early");
  endtask

  task automatic test_stop();
    int rd0 = run_done_cnt;
    int h;
    sb_push(2, 1'b1);
    do_start(5);
    sample_ctrl(1, 1);
    stop = 1'b1;
    sample_ctrl(1, 1);
    wait_idle();
    stop = 1'b0;
    h = fw_hs_cnt;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (run_done_cnt != rd0 || busy !== 1'b0 || fw_hs_cnt != h || sample_idx !== '0) begin
      errors++;
      $display("FAIL stop: run_done count=%0d busy=%0b extra fw=%0d idx=%0d, required 0 0 0 0",
               run_done_cnt - rd0, busy, fw_hs_cnt - h, sample_idx);
    end
    check_sb_empty("stop");
  endtask

  task automatic test_timeout();
    bit ok;
    int n = 0;
    sb_push(1, 1'b0);
    do_start(1);
    wait_fw_last(ok);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (timeout) begin n = i; break; end
    end
    checks++;
    if (n < 15 || n > 18) begin
      errors++;
      $display("FAIL timeout_time: fired after %0d cycles, required 15..18", n);
    end
    checks++;
    if (timeout !== 1'b1 || fw_valid !== 1'b0 || bw_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state: to=%0b fv=%0b bv=%0b busy=%0b, required 1 0 0 0",
               timeout, fw_valid, bw_valid, busy);
    end
    @(posedge clk); #1;
    do_start(1);
    repeat (4) @(negedge clk);
    checks++;
    if (fw_valid !== 1'b0 || busy !== 1'b0 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_start_ignored: fv=%0b busy=%0b to=%0b, required 0 0 1",
               fw_valid, busy, timeout);
    end
    @(posedge clk); #1;
    check_sb_empty("timeout");
    apply_reset();
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: to=%0b busy=%0b, required 0 0", timeout, busy);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    fork
      monitor();
      ready_driver();
    join_none
    test_reset();
    test_single();
    test_backpressure();
    test_multi();
    test_early_fw_done();
    test_stop();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
